mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative HI/LO multiply/divide unit for the single-cycle MIPS core. It executes MULT, MULTU,
//   DIV, DIVU, MTHI and MTLO, and holds the HI and LO registers.
//   Operands come from the register-file read ports (read_reg1 = rs, read_reg2 = rt). hi/lo feed
//   the MFHI/MFLO write-back mux. The control unit stalls pc_next while busy is high.
// PARAMETERS
//   DATA_W  32  operand and HI/LO width; iteration count equals DATA_W
// PORTS
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous reset, active low
//   start    in   1       1-cycle request to begin op, sampled only in IDLE
//   op       in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val   in   DATA_W  multiplicand / dividend
//   rt_val   in   DATA_W  multiplier / divisor
//   mthi     in   1       write rs_val to HI (IDLE only)
//   mtlo     in   1       write rs_val to LO (IDLE only)
//   busy     out  1       operation in progress
//   done     out  1       1-cycle pulse: HI/LO just updated by an op
//   hi       out  DATA_W  HI register
//   lo       out  DATA_W  LO register
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//   Reset mid-operation abandons the op; HI/LO are zeroed.
// - States: IDLE -> CALC -> FIX -> IDLE.
// - IDLE, edge with start=1:
//   - latch |rs| and |rt| (magnitudes for signed ops, raw values for unsigned ops);
//   - latch the sign flags and op; counter=0; go to CALC; busy=1 from the next cycle.
// - CALC: one iteration per edge, counter+1; after DATA_W iterations go to FIX.
//   - Multiply: shift-add over a 2*DATA_W accumulator.
//   - Divide: restoring; remainder DATA_W+1 bits, quotient shifts into LO.
// - FIX edge:
//   - sign-correct the result and write HI/LO; done=1 for exactly one cycle; busy=0; go to IDLE.
//   - MULT: negate the 2*DATA_W product when sign(rs)^sign(rt).
//   - DIV: negate the quotient when the signs differ; the remainder takes the dividend's sign.
// - Latency: start at edge E0 -> HI/LO valid and done=1 after edge E0+DATA_W+1 (33 edges at 32).
//   busy is high for DATA_W+1 cycles.
// - Result placement:
//   - MULT/MULTU: HI = product[2W-1:W], LO = product[W-1:0].
//   - DIV/DIVU: LO = quotient, HI = remainder.
// - Divide by zero: full latency, no trap; LO = all ones, HI = rs_val (either signedness).
// - Signed overflow (-2^(W-1) / -1): LO = 0x80000000, HI = 0.
// - Boundary and arbitration rules:
//   - start while busy: ignored, no queueing.
//   - mthi/mtlo while busy: ignored.
//   - mthi and mtlo together in IDLE: both written on the same edge.
//   - start together with mthi/mtlo in IDLE: start wins, moves are dropped.
// - The operand ports are not read after E0; rs_val/rt_val may change during CALC.
// - hi/lo hold their value except at the FIX edge or an mthi/mtlo edge.
//   done does not pulse on mthi/mtlo.
// CONFIGURATION
//   MDU_FAST_MUL_EN:
//   - Defined: MULT/MULTU compute a full-width product with the * operator at the start edge and
//     go IDLE -> FIX directly, skipping CALC. done follows the edge after E0; busy=1 for 1 cycle.
//     Divide is unchanged.
//   - Undefined: multiply is iterative with DATA_W+1 latency, and no * operator is synthesised.
// TESTING
// - MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 33 edges done=1, HI=0xFFFFFFFE, LO=0x00000001.
// - MULT rs=-7 (0xFFFFFFF9) rt=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 33 cycles.
// - DIV rs=-7 rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//   DIVU rs=100 rt=7 -> LO=14, HI=2.
// - DIVU rs=0x12345678 rt=0 -> LO=0xFFFFFFFF, HI=0x12345678.
//   DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
// - Start DIVU, pulse start and mthi at cycle 5 -> both ignored; final HI/LO are from the first
//   op only.
//   In IDLE, mthi=mtlo=1 with rs=0xA5 -> HI=LO=0xA5, done stays 0.
// - Assert rst_n=0 at cycle 10 of a MULT -> busy=0, HI=LO=0 immediately; a new start after
//   release runs normally.
//   With MDU_FAST_MUL_EN, MULT 6*7 -> done one edge after start, LO=42.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// HI/LO multiply/divide unit request/response bundle.
// master = control/datapath side, slave = mult_div_unit.
interface mdu_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              mthi;
    logic              mtlo;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, rs_val, rt_val, mthi, mtlo,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, rs_val, rt_val, mthi, mtlo,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; also services MTHI/MTLO.
// Optional MDU_FAST_MUL_EN: single-cycle multiply via '*', divide stays iterative.
module mult_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    localparam int unsigned W     = DATA_W;
    localparam int unsigned P_W   = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [W-1:0]     acc_hi, acc_hi_next;
    logic [W-1:0]     acc_lo, acc_lo_next;
    logic [W-1:0]     opb, opb_next;
    logic [W-1:0]     hi_q, hi_next;
    logic [W-1:0]     lo_q, lo_next;
    logic             is_div, is_div_next;
    logic             neg_a, neg_a_next;
    logic             neg_b, neg_b_next;
    logic             div0, div0_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;

    logic             sgn_a, sgn_b;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       mul_sum, div_trial, div_diff;
    logic [P_W-1:0]   prod_mag, prod_fix;
    logic [W-1:0]     quo_fix, rem_fix;

    // Operand magnitudes, one iteration step of each algorithm, and final sign fix-up
    always_comb begin
        sgn_a     = ~bus.op[0] & bus.rs_val[W-1];
        sgn_b     = ~bus.op[0] & bus.rt_val[W-1];
        mag_a     = sgn_a ? (~bus.rs_val + W'(1)) : bus.rs_val;
        mag_b     = sgn_b ? (~bus.rt_val + W'(1)) : bus.rt_val;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
        div_trial = {acc_hi, acc_lo[W-1]};
        div_diff  = div_trial - {1'b0, opb};
        prod_mag  = {acc_hi, acc_lo};
        prod_fix  = (neg_a ^ neg_b) ? (~prod_mag + P_W'(1)) : prod_mag;
        quo_fix   = (neg_a ^ neg_b) ? (~acc_lo + W'(1)) : acc_lo;
        rem_fix   = neg_a ? (~acc_hi + W'(1)) : acc_hi;
    end

    // Next-state and register update logic
    always_comb begin
        state_next  = state;
        count_next  = count;
        acc_hi_next = acc_hi;
        acc_lo_next = acc_lo;
        opb_next    = opb;
        hi_next     = hi_q;
        lo_next     = lo_q;
        is_div_next = is_div;
        neg_a_next  = neg_a;
        neg_b_next  = neg_b;
        div0_next   = div0;
        busy_next   = busy_q;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    is_div_next = bus.op[1];
                    neg_a_next  = sgn_a;
                    neg_b_next  = sgn_b;
                    div0_next   = (bus.rt_val == '0);
                    acc_hi_next = '0;
                    acc_lo_next = mag_a;
                    opb_next    = mag_b;
                    count_next  = '0;
                    busy_next   = 1'b1;
                    state_next  = CALC;
`ifdef MDU_FAST_MUL_EN
                    if (!bus.op[1]) begin
                        {acc_hi_next, acc_lo_next} = P_W'(mag_a) * P_W'(mag_b);
                        state_next = FIX;
                    end
`endif
                end else begin
                    if (bus.mthi) hi_next = bus.rs_val;
                    if (bus.mtlo) lo_next = bus.rs_val;
                end
            end
            CALC: begin
                count_next = count + CNT_W'(1);
                if (is_div) begin
                    acc_hi_next = div_diff[W] ? div_trial[W-1:0] : div_diff[W-1:0];
                    acc_lo_next = {acc_lo[W-2:0], ~div_diff[W]};
                end else begin
                    acc_hi_next = mul_sum[W:1];
                    acc_lo_next = {mul_sum[0], acc_lo[W-1:1]};
                end
                if (count == CNT_W'(W - 1)) state_next = FIX;
            end
            FIX: begin
                if (is_div) begin
                    lo_next = div0 ? '1 : quo_fix;
                    hi_next = rem_fix;
                end else begin
                    {hi_next, lo_next} = prod_fix;
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            acc_hi <= acc_hi_next;
            acc_lo <= acc_lo_next;
            opb    <= opb_next;
            hi_q   <= hi_next;
            lo_q   <= lo_next;
            is_div <= is_div_next;
            neg_a  <= neg_a_next;
            neg_b  <= neg_b_next;
            div0   <= div0_next;
            busy_q <= busy_next;
            done_q <= done_next;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, popped on each done pulse.
// Honours MDU_FAST_MUL_EN for the multiply latency expectation.
module tb_mult_div_unit;
    localparam int unsigned W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mdu_if #(.DATA_W(W)) bus ();

    mult_div_unit #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp;
    logic [63:0] mon_e;
    int          bc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference HI/LO from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            check("expectation_pending_at_done", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("hi", {32'd0, bus.hi}, {32'd0, mon_e[63:32]});
                check("lo", {32'd0, bus.lo}, {32'd0, mon_e[31:0]});
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic mh = 1'b0, input logic ml = 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.mthi   = mh;
        bus.mtlo   = ml;
        last_exp   = model(o, a, b);
        exp_q.push_back(last_exp);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.op     = 2'($urandom);
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
    endtask

    task automatic wait_done(output int busy_cyc);
        int g;
        busy_cyc = 0;
        g = 0;
        while (bus.done !== 1'b1 && g < 200) begin
            if (bus.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            g++;
        end
        check("done_within_bound", 64'(g < 200), 64'd1);
        check("busy_low_with_done", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(o, a, b);
        wait_done(n);
        check("busy_cycles", 64'(n), (!o[1] && FAST) ? 64'd1 : 64'(W + 1));
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        #1;
        check("rst_hi",   {32'd0, bus.hi}, 64'd0);
        check("rst_lo",   {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo", {32'd0, bus.lo}, 64'h0000_0000_0000_0001);
        run(2'b00, 32'hFFFF_FFF9, 32'd3);
        check("mult_neg_lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFEB);
        run(2'b10, 32'hFFFF_FFF9, 32'd2);
        run(2'b11, 32'd100, 32'd7);
        check("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
        run(2'b11, 32'h1234_5678, 32'd0);
        run(2'b10, 32'hFFFF_FFF9, 32'd0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_overflow", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
        run(2'b00, 32'd6, 32'd7);

        // start and mthi during an op are both dropped
        issue(2'b11, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.mthi   = 1'b1;
        bus.op     = 2'b00;
        bus.rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mthi   = 1'b0;
        wait_done(bc);
        repeat (3) @(negedge clk);
        check("busy_ignore_result", {bus.hi, bus.lo}, last_exp);
        check("busy_ignore_no_second_op", {63'd0, bus.busy}, 64'd0);

        // mthi + mtlo together in IDLE
        @(negedge clk);
        bus.mthi   = 1'b1;
        bus.mtlo   = 1'b1;
        bus.rs_val = 32'h0000_00A5;
        @(negedge clk);
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        check("move_no_done", {63'd0, bus.done}, 64'd0);
        check("move_hi_lo", {bus.hi, bus.lo}, {32'h0000_00A5, 32'h0000_00A5});
        repeat (3) begin
            @(negedge clk);
            bus.rs_val = $urandom;
        end
        check("idle_hold", {bus.hi, bus.lo}, {32'h0000_00A5, 32'h0000_00A5});

        // start with moves in IDLE: start wins
        issue(2'b01, 32'd5, 32'd6, 1'b1, 1'b1);
        wait_done(bc);
        check("start_over_move", {bus.hi, bus.lo}, 64'd30);

        // asynchronous reset mid-multiply
        issue(2'b00, 32'd123, 32'hFFFF_FFD3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("midop_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(2'b00, 32'd123, 32'hFFFF_FFD3);

        for (int i = 0; i < 40; i++) run(2'($urandom), pick(), pick());

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
